incline_cond: RTL and testbench



---
 rtl/incline_pkg.sv | 22 ++
 rtl/incline_cond_if.sv | 20 ++
 rtl/incline_window.sv | 48 ++++
 rtl/incline_cond.sv | 86 ++++++++
 tb/tb_incline_cond.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/incline_pkg.sv
// Shared types, saturation limits and the saturate helper for the incline conditioner.
package incline_pkg;

    typedef enum logic [1:0] {
        FLAT    = 2'd0,
        CLIMB   = 2'd1,
        DESCEND = 2'd2
    } hill_t;

    localparam logic signed [9:0] SAT_MAX = 10'sd511;
    localparam logic signed [9:0] SAT_MIN = -10'sd512;

    function automatic logic signed [9:0] saturate(input logic signed [12:0] x);
        if (x > 13'sd511)
            return SAT_MAX;
        else if (x < -13'sd512)
            return SAT_MIN;
        else
            return x[9:0];
    endfunction

endpackage

// File: rtl/incline_cond_if.sv
// Sample/average bus between the inertial interface, the conditioner and the motor stage.
interface incline_cond_if;
    logic signed [12:0] incline;
    logic               vld;
    logic               flush;
    logic signed [9:0]  avg_incline;
    logic               avg_vld;
    logic               climb;
    logic               descend;

    modport master (
        output incline, vld, flush,
        input  avg_incline, avg_vld, climb, descend
    );

    modport slave (
        input  incline, vld, flush,
        output avg_incline, avg_vld, climb, descend
    );
endinterface

// File: rtl/incline_window.sv
// Circular sample window with running sum; exposes the post-write sum and a full flag.
module incline_window
    import incline_pkg::*;
#(
    parameter int WIN_LOG2 = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_vld,
    input  logic                         i_flush,
    input  logic signed [9:0]            i_sat,
    output logic signed [10+WIN_LOG2-1:0] o_sum_next,
    output logic                         o_full_next
);
    localparam int DEPTH = 1 << WIN_LOG2;
    localparam int SW    = 10 + WIN_LOG2;
    localparam logic [WIN_LOG2:0] FILL_FULL = (WIN_LOG2 + 1)'(DEPTH);

    logic signed [9:0]    r_buf [DEPTH];
    logic [WIN_LOG2-1:0]  r_wr_ptr;
    logic [WIN_LOG2:0]    r_fill;
    logic signed [SW-1:0] r_sum;

    logic                 w_write;
    logic [WIN_LOG2:0]    w_fill_next;

    assign w_write     = i_vld && !i_flush;
    assign o_sum_next  = r_sum + SW'(i_sat) - SW'(r_buf[r_wr_ptr]);
    assign w_fill_next = (r_fill == FILL_FULL) ? r_fill : r_fill + 1'b1;
    assign o_full_next = w_write && (w_fill_next == FILL_FULL);

    always_ff @(posedge clk) begin
        // NOTE: the buffer is cleared on reset/flush because the running sum subtracts the evicted entry.
        if (rst || i_flush) begin
            for (int i = 0; i < DEPTH; i++)
                r_buf[i] <= '0;
            r_wr_ptr <= '0;
            r_fill   <= '0;
            r_sum    <= '0;
        end else if (w_write) begin
            r_buf[r_wr_ptr] <= i_sat;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
            r_fill          <= w_fill_next;
            r_sum           <= o_sum_next;
        end
    end

endmodule

// File: rtl/incline_cond.sv
// Incline conditioner: saturate, window-average and classify the slope with hysteresis.
module incline_cond
    import incline_pkg::*;
#(
    parameter int               WIN_LOG2  = 2,
    parameter logic signed [9:0] CLIMB_ON  = 10'sd100,
    parameter logic signed [9:0] CLIMB_OFF = 10'sd60,
    parameter logic signed [9:0] DESC_ON   = -10'sd100,
    parameter logic signed [9:0] DESC_OFF  = -10'sd60
) (
    input  logic          clk,
    input  logic          rst,
    incline_cond_if.slave bus
);
    localparam logic [1:0] S_FLAT    = FLAT;
    localparam logic [1:0] S_CLIMB   = CLIMB;
    localparam logic [1:0] S_DESCEND = DESCEND;

    logic signed [9:0]            w_sat;
    logic signed [10+WIN_LOG2-1:0] w_sum_next;
    logic                         w_full_next;
    logic [1:0]                   w_state_next;

    logic signed [9:0]            r_avg;
    logic                         r_avg_vld;
    logic [1:0]                   r_state;

    assign w_sat = saturate(bus.incline);

    incline_window #(.WIN_LOG2(WIN_LOG2)) u_window (
        .clk        (clk),
        .rst        (rst),
        .i_vld      (bus.vld),
        .i_flush    (bus.flush),
        .i_sat      (w_sat),
        .o_sum_next (w_sum_next),
        .o_full_next(w_full_next)
    );

    // Arithmetic shift gives the floored average, also for negative sums.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_avg     <= '0;
            r_avg_vld <= 1'b0;
        end else begin
            r_avg_vld <= w_full_next;
            if (w_full_next)
                r_avg <= 10'(w_sum_next >>> WIN_LOG2);
        end
    end

    always_comb begin
        // NOTE: default first so every path assigns the next state and no latch is inferred.
        w_state_next = r_state;
        if (r_avg_vld) begin
            case (r_state)
                S_FLAT: begin
                    if (r_avg >= CLIMB_ON)     w_state_next = S_CLIMB;
                    else if (r_avg <= DESC_ON) w_state_next = S_DESCEND;
                end
                S_CLIMB: begin
                    if (r_avg <= DESC_ON)        w_state_next = S_DESCEND;
                    else if (r_avg < CLIMB_OFF)  w_state_next = S_FLAT;
                end
                S_DESCEND: begin
                    if (r_avg >= CLIMB_ON)       w_state_next = S_CLIMB;
                    else if (r_avg > DESC_OFF)   w_state_next = S_FLAT;
                end
                default: w_state_next = S_FLAT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.flush)
            r_state <= S_FLAT;
        else
            r_state <= w_state_next;
    end

    assign bus.avg_incline = r_avg;
    assign bus.avg_vld     = r_avg_vld;
    assign bus.climb       = (r_state == S_CLIMB);
    assign bus.descend     = (r_state == S_DESCEND);

endmodule

// File: tb/tb_incline_cond.sv
// Directed plus random stimulus against a queue-based window/hill reference model.
module tb_incline_cond;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    incline_cond_if bus ();

    incline_cond dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Reference model state
    int win[$];
    int exp_avg     = 0;
    int exp_avg_vld = 0;
    int exp_hill    = 0; // 0 flat, 1 climb, 2 descend

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic int sat_ref(input int x);
        if (x > 511)  return 511;
        if (x < -512) return -512;
        return x;
    endfunction

    function automatic int floor_div(input int s, input int d);
        if (s >= 0) return s / d;
        return -((-s + d - 1) / d);
    endfunction

    task automatic model(input int inc, input bit v, input bit fl, input bit r);
        int prev_avg = exp_avg;
        int prev_vld = exp_avg_vld;
        int s = 0;
        if (r) begin
            win.delete();
            exp_avg = 0; exp_avg_vld = 0; exp_hill = 0;
        end else if (fl) begin
            win.delete();
            exp_avg_vld = 0; exp_hill = 0;
        end else begin
            if (prev_vld != 0) begin
                case (exp_hill)
                    0: if (prev_avg >= 100) exp_hill = 1; else if (prev_avg <= -100) exp_hill = 2;
                    1: if (prev_avg <= -100) exp_hill = 2; else if (prev_avg < 60) exp_hill = 0;
                    default: if (prev_avg >= 100) exp_hill = 1; else if (prev_avg > -60) exp_hill = 0;
                endcase
            end
            exp_avg_vld = 0;
            if (v) begin
                win.push_back(sat_ref(inc));
                if (win.size() > DEPTH) void'(win.pop_front());
                if (win.size() == DEPTH) begin
                    foreach (win[i]) s += win[i];
                    exp_avg = floor_div(s, DEPTH);
                    exp_avg_vld = 1;
                end
            end
        end
    endtask

    task automatic step(input int inc, input bit v, input bit fl = 1'b0, input bit r = 1'b0);
        @(negedge clk);
        bus.incline = 13'(inc);
        bus.vld     = v;
        bus.flush   = fl;
        rst         = r;
        @(posedge clk);
        #1;
        model(inc, v, fl, r);
        check("avg_vld", 32'(bus.avg_vld), exp_avg_vld);
        check("avg_incline", 32'(bus.avg_incline), exp_avg);
        check("climb", 32'(bus.climb), (exp_hill == 1) ? 1 : 0);
        check("descend", 32'(bus.descend), (exp_hill == 2) ? 1 : 0);
    endtask

    initial begin
        bus.incline = '0; bus.vld = 1'b0; bus.flush = 1'b0; rst = 1'b1;

        // Reset state
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        check("reset_avg", 32'(bus.avg_incline), 0);

        // Saturation high then low
        repeat (4) step(4095, 1);
        check("sat_hi", 32'(bus.avg_incline), 511);
        step(0, 0);
        repeat (4) step(-4096, 1);
        check("sat_lo", 32'(bus.avg_incline), -512);
        step(0, 0, 1);

        // Fill and latency
        step(10, 1); step(20, 1); step(30, 1);
        step(40, 1);
        check("fill_avg25", 32'(bus.avg_incline), 25);
        step(0, 0);
        step(50, 1);
        check("fill_avg35", 32'(bus.avg_incline), 35);
        step(0, 0, 1);

        // Floor rounding of a negative sum
        step(-1, 1); step(-1, 1); step(-1, 1); step(-2, 1);
        check("floor_neg", 32'(bus.avg_incline), -2);
        step(0, 0, 1);

        // Hysteresis walk
        repeat (4) step(120, 1);
        step(0, 0);
        check("climb_on", 32'(bus.climb), 1);
        repeat (4) begin step(80, 1); step(0, 0); end
        repeat (6) begin step(40, 1); step(0, 0); end
        check("climb_off", 32'(bus.climb), 0);
        repeat (6) begin step(-150, 1); step(0, 0); end
        check("descend_on", 32'(bus.descend), 1);

        // Flush coincident with a sample
        step(300, 1, 1);
        check("flush_flat", 32'(bus.descend), 0);
        step(1, 1); step(2, 1); step(3, 1);
        step(4, 1);
        step(0, 0, 1);

        // Back-to-back samples 0..7
        for (int k = 0; k < 8; k++) step(k, 1);
        check("b2b_last", 32'(bus.avg_incline), 5);

        // Reset mid-stream
        step(500, 1); step(500, 1);
        step(0, 0, 0, 1);
        check("rst_mid", 32'(bus.avg_incline), 0);

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            int  v;
            bit  r, fl, vl;
            v  = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 8191)) - 4096
                                             : int'($urandom_range(0, 600)) - 300;
            vl = ($urandom_range(0, 3) != 0);
            fl = ($urandom_range(0, 39) == 0);
            r  = ($urandom_range(0, 99) == 0);
            step(v, vl, fl, r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
